// File: rtl/mul_arb_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter.
package fv_enc_pkg;
    localparam int N_DEF  = 4;
    localparam int QW_DEF = 5;
    localparam int UW_DEF = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_IN, ST_OUT} mul_arb_state_t;
endpackage

// File: rtl/mul_arb_if.sv
// Valid/ready stream with a last marker; "in" is the consumer side, "out" the producer side.
interface axis_if #(parameter int W = 5);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    logic         last;

    modport in  (input  data, vld, last, output rdy);
    modport out (output data, vld, last, input  rdy);
endinterface

// File: rtl/mul_arb_rr_arb2.sv
// Two-input round-robin: registered last winner, combinational one-hot grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       a_rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_o = req_i;
        if (&req_i) gnt_o = last_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && |req_i) last_d = gnt_o[1];
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/mul_arb.sv
// Shares one polynomial multiplier between two requesters: N input beats in, N results out.
module mul_arb
    import fv_enc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int QW = QW_DEF,
    parameter int UW = UW_DEF
) (
    input  logic       clk,
    input  logic       a_rst_n,
    axis_if.in         r0_p,
    axis_if.in         r1_p,
    axis_if.in         r0_u,
    axis_if.in         r1_u,
    axis_if.out        r0_z,
    axis_if.out        r1_z,
    axis_if.out        m_p,
    axis_if.out        m_u,
    axis_if.in         m_z,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [1:0] err
);
    localparam int CW = $clog2(N) + 1;

    mul_arb_state_t state_q, state_d;
    logic           own_q, own_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     err_q, err_d;

    logic [1:0]     req, arb_gnt;
    logic           arb_upd;
    logic           pv, uv, pl, ul, zr, beat;
    logic [QW-1:0]  pd;
    logic [UW-1:0]  ud;

    assign req = {r1_p.vld & r1_u.vld, r0_p.vld & r0_u.vld};

    rr_arb2 u_arb (
        .clk    (clk),
        .a_rst_n(a_rst_n),
        .req_i  (req),
        .upd_i  (arb_upd),
        .gnt_o  (arb_gnt)
    );

    // Owner-selected view of the requester streams.
    assign pv   = own_q ? r1_p.vld  : r0_p.vld;
    assign uv   = own_q ? r1_u.vld  : r0_u.vld;
    assign pl   = own_q ? r1_p.last : r0_p.last;
    assign ul   = own_q ? r1_u.last : r0_u.last;
    assign pd   = own_q ? r1_p.data : r0_p.data;
    assign ud   = own_q ? r1_u.data : r0_u.data;
    assign zr   = own_q ? r1_z.rdy  : r0_z.rdy;
    assign beat = pv & uv & m_p.rdy & m_u.rdy;

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        arb_upd    = 1'b0;
        r0_p.rdy   = 1'b0;
        r1_p.rdy   = 1'b0;
        r0_u.rdy   = 1'b0;
        r1_u.rdy   = 1'b0;
        r0_z.data  = '0;
        r0_z.vld   = 1'b0;
        r0_z.last  = 1'b0;
        r1_z.data  = '0;
        r1_z.vld   = 1'b0;
        r1_z.last  = 1'b0;
        m_p.data   = '0;
        m_p.vld    = 1'b0;
        m_p.last   = 1'b0;
        m_u.data   = '0;
        m_u.vld    = 1'b0;
        m_u.last   = 1'b0;
        m_z.rdy    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    arb_upd = 1'b1;
                    own_d   = (arb_gnt == 2'b10);
                    cnt_d   = '0;
                    state_d = ST_IN;
                end
            end
            ST_IN: begin
                // A beat needs both coefficient streams; p alone forwards nothing.
                m_p.data = pd;
                m_p.last = pl;
                m_p.vld  = pv & uv;
                m_u.data = ud;
                m_u.last = ul;
                m_u.vld  = pv & uv;
                if (own_q) begin
                    r1_p.rdy = m_p.rdy;
                    r1_u.rdy = m_u.rdy;
                end else begin
                    r0_p.rdy = m_p.rdy;
                    r0_u.rdy = m_u.rdy;
                end
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_OUT;
                        cnt_d   = '0;
                    end else if (pl || ul) begin
                        state_d  = ST_OUT;
                        cnt_d    = '0;
                        err_d[0] = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                // The multiplier cannot stall, so a result the owner refuses is lost.
                m_z.rdy = 1'b1;
                if (own_q) begin
                    r1_z.data = m_z.data;
                    r1_z.vld  = m_z.vld;
                    r1_z.last = m_z.last;
                end else begin
                    r0_z.data = m_z.data;
                    r0_z.vld  = m_z.vld;
                    r0_z.last = m_z.last;
                end
                if (m_z.vld) begin
                    if (!zr) err_d[1] = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (m_z.last || cnt_q == CW'(N - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= ST_IDLE;
            own_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign gnt  = (state_q == ST_IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
    assign err  = err_q;
endmodule

// File: tb/tb_mul_arb.sv
// Directed bench: two requester sources, a pass-through multiplier model, result capture.
module tb_mul_arb;
    localparam int N  = 4;
    localparam int QW = 5;
    localparam int UW = 1;

    logic       clk = 1'b0;
    logic       a_rst_n;
    logic [1:0] gnt, err;
    logic       busy;

    axis_if #(.W(QW)) r0_p(), r1_p(), r0_z(), r1_z(), m_p(), m_z();
    axis_if #(.W(UW)) r0_u(), r1_u(), m_u();

    mul_arb #(.N(N), .QW(QW), .UW(UW)) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .r0_p(r0_p), .r1_p(r1_p), .r0_u(r0_u), .r1_u(r1_u),
        .r0_z(r0_z), .r1_z(r1_z), .m_p(m_p), .m_u(m_u), .m_z(m_z),
        .gnt(gnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit en[2], zrdy[2];
    int idx[2], len[2], rep[2], base[2], gap_at[2], u_gap[2];
    bit gap_done[2];
    int zq0[$], zq1[$];
    int zl0, zl1, z1v, gap_viol, cyc;
    bit saw_out, memit;
    logic [QW-1:0] mbuf[$];
    logic [1:0] tg[$];
    int tt[$];
    logic [1:0] gprev;
    int exp3[8] = '{1, 0, 2, 0, 1, 0, 2, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic init_tb();
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; zrdy[i] = 1; idx[i] = 0; len[i] = N; rep[i] = 0;
            base[i] = 0; gap_at[i] = -1; u_gap[i] = 0; gap_done[i] = 0;
        end
        mbuf.delete();
        memit = 0;
    endtask

    task automatic clr();
        zq0.delete(); zq1.delete(); tg.delete(); tt.delete();
        zl0 = 0; zl1 = 0; z1v = 0; gap_viol = 0; saw_out = 0; gprev = gnt;
    endtask

    task automatic start(input int i, input int l, input int r, input int b);
        en[i] = 1; idx[i] = 0; len[i] = l; rep[i] = r; base[i] = b;
        gap_at[i] = -1; gap_done[i] = 0; u_gap[i] = 0;
    endtask

    task automatic drive();
        r0_p.vld  = en[0];
        r0_p.data = QW'(base[0] + idx[0]);
        r0_p.last = en[0] && (idx[0] == len[0] - 1);
        r0_u.vld  = en[0] && (u_gap[0] == 0);
        r0_u.data = UW'(idx[0] == 0);
        r0_u.last = r0_p.last;
        r0_z.rdy  = zrdy[0];
        r1_p.vld  = en[1];
        r1_p.data = QW'(base[1] + idx[1]);
        r1_p.last = en[1] && (idx[1] == len[1] - 1);
        r1_u.vld  = en[1] && (u_gap[1] == 0);
        r1_u.data = UW'(idx[1] == 0);
        r1_u.last = r1_p.last;
        r1_z.rdy  = zrdy[1];
        m_p.rdy = 1'b1;
        m_u.rdy = 1'b1;
        if (memit && mbuf.size() > 0) begin
            m_z.data = mbuf.pop_front();
            m_z.vld  = 1'b1;
            m_z.last = (mbuf.size() == 0);
        end else begin
            m_z.data = '0;
            m_z.vld  = 1'b0;
            m_z.last = 1'b0;
            memit    = 0;
        end
    endtask

    task automatic sample();
        bit b[2];
        cyc++;
        if (gnt !== gprev) begin
            tg.push_back(gnt); tt.push_back(cyc); gprev = gnt;
        end
        if (m_z.rdy) saw_out = 1;
        if (r1_z.vld) z1v++;
        if (m_p.vld && m_p.rdy && m_u.vld && m_u.rdy) begin
            mbuf.push_back(m_p.data);
            if (m_p.last || mbuf.size() == N) memit = 1;
        end
        if ((u_gap[0] > 0 || u_gap[1] > 0) && m_u.vld) gap_viol++;
        if (r0_z.vld && r0_z.rdy) begin
            zq0.push_back(int'(r0_z.data));
            if (r0_z.last) zl0 = zq0.size();
        end
        if (r1_z.vld && r1_z.rdy) begin
            zq1.push_back(int'(r1_z.data));
            if (r1_z.last) zl1 = zq1.size();
        end
        b[0] = r0_p.vld & r0_p.rdy & r0_u.vld & r0_u.rdy;
        b[1] = r1_p.vld & r1_p.rdy & r1_u.vld & r1_u.rdy;
        for (int i = 0; i < 2; i++) begin
            if (u_gap[i] > 0) u_gap[i]--;
            if (b[i]) begin
                idx[i]++;
                if (idx[i] == gap_at[i] && !gap_done[i]) begin
                    u_gap[i] = 3; gap_done[i] = 1;
                end
                if (idx[i] == len[i]) begin
                    idx[i] = 0; rep[i]--;
                    if (rep[i] <= 0) en[i] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask

    task automatic run_done(input string tag, input int maxc);
        int k = 0;
        do begin
            cycle();
            k++;
        end while ((en[0] || en[1] || busy || memit) && k < maxc);
        chk(tag, k < maxc, 1);
    endtask

    task automatic do_reset();
        a_rst_n = 1'b0;
        init_tb();
        repeat (2) cycle();
        a_rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        a_rst_n = 1'b0;
        init_tb();
        drive();
        cycle();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_err", err, 0);
        chk("rst_mpv", m_p.vld, 0);
        chk("rst_mzr", m_z.rdy, 0);
        a_rst_n = 1'b1;
        cycle();

        // Single requester, identity multiply.
        clr();
        start(0, 4, 1, 1);
        cycle();
        chk("t1_bubble", gnt, 0);
        chk("t1_r0prdy_idle", r0_p.rdy, 0);
        cycle();
        chk("t1_gnt", gnt, 2'b01);
        run_done("t1_timeout", 100);
        chk("t1_cnt", zq0.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t1_z%0d", k), zq0.size() > k ? zq0[k] : -1, k + 1);
        chk("t1_last", zl0, 4);
        chk("t1_r1zv", z1v, 0);
        chk("t1_err", err, 0);

        // Simultaneous requests after reset: r0 first, r1 one idle cycle later.
        do_reset();
        clr();
        start(0, 4, 1, 1);
        start(1, 4, 1, 9);
        run_done("t2_timeout", 150);
        chk("t2_tsize", tg.size(), 4);
        chk("t2_g0", tg.size() > 0 ? tg[0] : 2'b11, 2'b01);
        chk("t2_g1", tg.size() > 1 ? tg[1] : 2'b11, 2'b00);
        chk("t2_g2", tg.size() > 2 ? tg[2] : 2'b11, 2'b10);
        chk("t2_gap", tt.size() > 2 ? tt[2] - tt[1] : -1, 1);
        chk("t2_r1z0", zq1.size() > 0 ? zq1[0] : -1, 9);
        chk("t2_r1cnt", zq1.size(), 4);

        // Both keep requesting: grants alternate.
        clr();
        start(0, 4, 2, 1);
        start(1, 4, 2, 17);
        run_done("t3_timeout", 300);
        chk("t3_tsize", tg.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_g%0d", k), tg.size() > k ? tg[k] : 2'b11, exp3[k]);
        chk("t3_r0cnt", zq0.size(), 8);
        chk("t3_r1cnt", zq1.size(), 8);

        // u.vld gap mid-polynomial.
        clr();
        start(0, 4, 1, 3);
        gap_at[0] = 2;
        run_done("t4_timeout", 100);
        chk("t4_gapviol", gap_viol, 0);
        chk("t4_cnt", zq0.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t4_z%0d", k), zq0.size() > k ? zq0[k] : -1, k + 3);
        chk("t4_last", zl0, 4);

        // Early last on beat 2.
        clr();
        start(0, 2, 1, 1);
        run_done("t5_timeout", 100);
        chk("t5_err", err, 2'b01);
        chk("t5_out", saw_out, 1);
        chk("t5_cnt", zq0.size(), 2);
        clr();
        start(0, 4, 1, 1);
        run_done("t5b_timeout", 100);
        chk("t5_sticky", err, 2'b01);

        // Owner refuses results.
        clr();
        zrdy[0] = 0;
        start(0, 4, 1, 1);
        run_done("t6_timeout", 100);
        chk("t6_err", err, 2'b11);
        chk("t6_cnt", zq0.size(), 0);
        zrdy[0] = 1;

        // Asynchronous reset in ST_IN.
        clr();
        start(0, 4, 1, 1);
        cycle();
        cycle();
        chk("t7_gnt", gnt, 2'b01);
        cycle();
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_gnt0", gnt, 0);
        chk("t7_err", err, 0);
        chk("t7_mpv", m_p.vld, 0);
        init_tb();
        repeat (2) cycle();
        a_rst_n = 1'b1;
        clr();
        start(0, 4, 1, 5);
        run_done("t7b_timeout", 100);
        chk("t7_cnt", zq0.size(), 4);
        chk("t7_z0", zq0.size() > 0 ? zq0[0] : -1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter N, default 4, coefficients per polynomial; power of two, at least 2.
REQ-002 Parameter QW, default 5, P-coefficient and result width.
REQ-003 Parameter UW, default 1, U-coefficient width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 a_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 r0_p, r1_p  axis_if.in  QW  requester P-coefficient streams.
REQ-007 r0_u, r1_u  axis_if.in  UW  requester U-coefficient streams.
REQ-008 r0_z, r1_z  axis_if.out  QW  per-requester result streams.
REQ-009 m_p  axis_if.out  QW  to multiplier P input.
REQ-010 m_u  axis_if.out  UW  to multiplier U input.
REQ-011 m_z  axis_if.in  QW  from multiplier result output.
REQ-012 gnt  out  2  one-hot current owner; 00 when idle.
REQ-013 busy  out  1  high in any state other than ST_IDLE.
REQ-014 err  out  2  sticky flags: [0] short input (last before N beats), [1] result dropped (owner z.rdy low on valid result).

Function
REQ-015 States: ST_IDLE, ST_IN, ST_OUT. Reset enters ST_IDLE.
REQ-016 Request i is active when ri_p.vld and ri_u.vld are both high.
REQ-017 ST_IDLE: if any request is active, register the grant and go to ST_IN on the next cycle; there is a one-cycle arbitration bubble.
REQ-018 Round-robin: on a simultaneous request, grant the requester not granted last; the last-grant register resets to 1, so requester 0 wins first.
REQ-019 A grant is held for one whole operation: N input beats, then N result beats.
REQ-020 ST_IN: m_p and m_u data, vld and last are combinational muxes of the owner's streams.
REQ-021 ST_IN ready: owner p.rdy and u.rdy equal m_p.rdy and m_u.rdy; the non-owner sees rdy=0.
REQ-022 An input beat is counted only when owner p.vld, owner u.vld, m_p.rdy and m_u.rdy are all high; vld on p without u forwards nothing.
REQ-023 Input beat counter width is clog2(N)+1; it clears on entry to ST_IN.
REQ-024 On the N-th beat, go to ST_OUT.
REQ-025 If last arrives on either stream before the N-th beat, go to ST_OUT and set err[0].
REQ-026 ST_IN: m_p.vld and m_u.vld are 0 outside the owner's gated beats.
REQ-027 ST_OUT: m_z data, vld and last route to the owner's z; non-owner z.vld=0.
REQ-028 ST_OUT: m_z.rdy is driven 1, because the multiplier does not accept backpressure.
REQ-029 A valid result beat while owner z.rdy=0 sets err[1]; the beat is lost and not retried.
REQ-030 Return to ST_IDLE on m_z.vld and m_z.last, or after N counted result beats, whichever comes first.
REQ-031 A new grant may issue in the cycle after returning to ST_IDLE.
REQ-032 In ST_IDLE all m_* vld are 0, all requester rdy are 0, m_z.rdy=0 and gnt=00.
REQ-033 The arbiter performs no arithmetic; data widths pass through unchanged.

Reset
REQ-034 Asserting a_rst_n low forces, asynchronously: ST_IDLE, counters 0, last-grant 1, gnt=00, busy=0, err=00, all vld/rdy/last outputs 0.
REQ-035 Reset in mid-operation abandons the transfer with no flush; the system resets the multiplier in the same window.
REQ-036 err clears only on reset.

Structure
REQ-037 A shared package fv_enc_pkg holds the state enum mul_arb_state_t and the default N, QW and UW localparams.
REQ-038 The arbitration decision is a sub-module rr_arb2: 2-input round-robin, registered last-grant, combinational one-hot grant.
REQ-039 Stream muxing and the FSM stay in mul_arb.

Verification
REQ-040 N=4; r0 only, p={1,2,3,4}, u={1,0,0,0} -> gnt=01 one cycle after vld; r0_z receives {1,2,3,4} with last on beat 4; r1_z.vld stays 0.
REQ-041 r0 and r1 request in the same cycle after reset -> r0 served first, then r1 granted the cycle after ST_IDLE; gnt sequence 01, 00, 10.
REQ-042 r1 holds requests continuously while r0 requests once per gap -> grants alternate 01, 10, 01; neither requester is granted twice in a row while both request.
REQ-043 Owner drops u.vld for 3 cycles mid-polynomial -> no m_u beat during the gap; beat count resumes; still exactly 4 results.
REQ-044 r0 asserts last on beat 2 -> err[0]=1, FSM enters ST_OUT; err stays set until reset.
REQ-045 Owner z.rdy held low during ST_OUT -> err[1]=1. Separately, a_rst_n pulsed low in ST_IN -> busy=0, gnt=00 immediately, without waiting for a clock edge.
